// File: rtl/vend_txn_ctrl.sv
// Vending transaction sequencer: collects coin credit, checks price, drives the
// dispenser over req/done, then pays change back one unit per cycle.
module vend_txn_ctrl #(
    parameter int CREDIT_W   = 4,
    parameter int MAX_CREDIT = 15,
    parameter int PRICE_0    = 1,
    parameter int PRICE_1    = 2,
    parameter int PRICE_2    = 3,
    parameter int PRICE_3    = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                coin_1,
    input  logic                coin_2,
    input  logic [1:0]          select,
    input  logic                sel_valid,
    input  logic                cancel,
    input  logic                disp_done,
    output logic                disp_req,
    output logic [1:0]          disp_sel,
    output logic                change,
    output logic                coin_reject,
    output logic                deny,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_VEND,
        ST_CHANGE
    } state_e;

    // state_q is the FSM state register; checkers bind to it directly.
    state_e              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [TMR_W-1:0]    tmr_q, tmr_d;
    logic                disp_req_q, disp_req_d;
    logic [1:0]          disp_sel_q, disp_sel_d;
    logic                change_q, change_d;
    logic                coin_reject_q, coin_reject_d;
    logic                deny_q, deny_d;
    logic                busy_q, busy_d;

    logic [1:0]          inc;
    logic [CREDIT_W:0]   sum;
    logic                coin_any;
    logic                coin_ok;
    logic [CREDIT_W-1:0] price;

    function automatic logic [CREDIT_W-1:0] price_of(input logic [1:0] s);
        case (s)
            2'd0:    price_of = CREDIT_W'(PRICE_0);
            2'd1:    price_of = CREDIT_W'(PRICE_1);
            2'd2:    price_of = CREDIT_W'(PRICE_2);
            default: price_of = CREDIT_W'(PRICE_3);
        endcase
    endfunction

    always_comb begin
        inc      = {1'b0, coin_1} + {coin_2, 1'b0};
        sum      = {1'b0, credit_q} + (CREDIT_W+1)'(inc);
        coin_any = coin_1 | coin_2;
        // A cycle's coins are taken whole or not at all.
        coin_ok  = coin_any && (sum <= (CREDIT_W+1)'(MAX_CREDIT));
        price    = price_of(select);

        state_d       = state_q;
        credit_d      = credit_q;
        tmr_d         = tmr_q;
        disp_req_d    = disp_req_q;
        disp_sel_d    = disp_sel_q;
        coin_reject_d = 1'b0;
        deny_d        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (coin_ok) begin
                    credit_d = sum[CREDIT_W-1:0];
                    tmr_d    = '0;
                    state_d  = ST_COLLECT;
                end else if (coin_any) begin
                    coin_reject_d = 1'b1;
                end
            end
            ST_COLLECT: begin
                if (!cancel && sel_valid && credit_q >= price) begin
                    state_d       = ST_VEND;
                    credit_d      = credit_q - price;
                    disp_req_d    = 1'b1;
                    disp_sel_d    = select;
                    coin_reject_d = coin_any;
                end else begin
                    if (coin_ok) begin
                        credit_d = sum[CREDIT_W-1:0];
                        tmr_d    = '0;
                    end else if (coin_any) begin
                        coin_reject_d = 1'b1;
                    end
                    if (cancel) begin
                        state_d = ST_CHANGE;
                    end else if (sel_valid) begin
                        deny_d = 1'b1;
                        tmr_d  = '0;
                    end else if (!coin_ok) begin
                        if (tmr_q == TMR_W'(TIMEOUT - 1)) begin
                            state_d = ST_CHANGE;
                        end else begin
                            tmr_d = tmr_q + 1'b1;
                        end
                    end
                end
            end
            ST_VEND: begin
                coin_reject_d = coin_any;
                if (disp_done) begin
                    disp_req_d = 1'b0;
                    state_d    = (credit_q != '0) ? ST_CHANGE : ST_IDLE;
                end
            end
            ST_CHANGE: begin
                coin_reject_d = coin_any;
                if (credit_q <= CREDIT_W'(1)) begin
                    credit_d = '0;
                    state_d  = ST_IDLE;
                end else begin
                    credit_d = credit_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        change_d = (state_d == ST_CHANGE);
        busy_d   = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            credit_q      <= '0;
            tmr_q         <= '0;
            disp_req_q    <= 1'b0;
            disp_sel_q    <= 2'b00;
            change_q      <= 1'b0;
            coin_reject_q <= 1'b0;
            deny_q        <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            tmr_q         <= tmr_d;
            disp_req_q    <= disp_req_d;
            disp_sel_q    <= disp_sel_d;
            change_q      <= change_d;
            coin_reject_q <= coin_reject_d;
            deny_q        <= deny_d;
            busy_q        <= busy_d;
        end
    end

    assign disp_req    = disp_req_q;
    assign disp_sel    = disp_sel_q;
    assign change      = change_q;
    assign coin_reject = coin_reject_q;
    assign deny        = deny_q;
    assign credit      = credit_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_vend_txn_ctrl.sv
// Directed bench for vend_txn_ctrl with hand-computed expected values.
module tb_vend_txn_ctrl;

    localparam int TIMEOUT = 255;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       coin_1 = 1'b0;
    logic       coin_2 = 1'b0;
    logic [1:0] select = 2'b00;
    logic       sel_valid = 1'b0;
    logic       cancel = 1'b0;
    logic       disp_done = 1'b0;
    logic       disp_req;
    logic [1:0] disp_sel;
    logic       change;
    logic       coin_reject;
    logic       deny;
    logic [3:0] credit;
    logic       busy;

    int n_cmp = 0;
    int n_bad = 0;
    logic [3:0] exp_q[$];

    vend_txn_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .coin_1     (coin_1),
        .coin_2     (coin_2),
        .select     (select),
        .sel_valid  (sel_valid),
        .cancel     (cancel),
        .disp_done  (disp_done),
        .disp_req   (disp_req),
        .disp_sel   (disp_sel),
        .change     (change),
        .coin_reject(coin_reject),
        .deny       (deny),
        .credit     (credit),
        .busy       (busy)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: sim time expired, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_coins(input logic c1, input logic c2);
        coin_1 = c1;
        coin_2 = c2;
        step();
        coin_1 = 1'b0;
        coin_2 = 1'b0;
    endtask

    task automatic pulse_sel(input logic [1:0] s);
        select    = s;
        sel_valid = 1'b1;
        step();
        sel_valid = 1'b0;
    endtask

    task automatic pulse_done();
        disp_done = 1'b1;
        step();
        disp_done = 1'b0;
    endtask

    task automatic flush(input string tag);
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        for (int i = 0; i < 32 && busy; i++) step();
        check(tag, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        // reset block
        repeat (3) @(posedge clk);
        #1;
        check("rst_credit", credit, 0);
        check("rst_busy", busy, 0);
        check("rst_outs", {disp_req, disp_sel, change, coin_reject, deny}, 0);
        reset = 1'b0;
        step();

        // 1: 1+2 coins, buy item 01 (price 2), coin during VEND rejected, 1 change
        drive_coins(1, 0);
        check("t1_credit1", credit, 1);
        check("t1_busy", busy, 1);
        drive_coins(0, 1);
        check("t1_credit3", credit, 3);
        pulse_sel(2'b01);
        check("t1_req", disp_req, 1);
        check("t1_sel", disp_sel, 1);
        check("t1_credit_after_vend", credit, 1);
        drive_coins(1, 0);
        check("t1_vend_coin_rej", coin_reject, 1);
        check("t1_vend_coin_credit", credit, 1);
        step();
        step();
        check("t1_req_held", disp_req, 1);
        check("t1_sel_held", disp_sel, 1);
        pulse_done();
        check("t1_req_drop", disp_req, 0);
        check("t1_change1", change, 1);
        step();
        check("t1_change_end", change, 0);
        check("t1_idle_credit", credit, 0);
        check("t1_idle_busy", busy, 0);

        // 2: deny on insufficient credit
        drive_coins(1, 0);
        pulse_sel(2'b11);
        check("t2_deny", deny, 1);
        check("t2_credit", credit, 1);
        check("t2_no_req", disp_req, 0);
        step();
        check("t2_deny_pulse", deny, 0);
        check("t2_still_collect", busy, 1);
        flush("t2_flush");

        // 3: cancel with credit 5 -> 5 change cycles counting down
        repeat (5) drive_coins(1, 0);
        check("t3_credit5", credit, 5);
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        for (int v = 5; v >= 1; v--) exp_q.push_back(4'(v));
        while (exp_q.size() > 0) begin
            logic [3:0] e;
            e = exp_q.pop_front();
            check("t3_change", change, 1);
            check("t3_credit", credit, e);
            step();
        end
        check("t3_change_off", change, 0);
        check("t3_credit0", credit, 0);
        check("t3_busy0", busy, 0);

        // 4: ceiling behaviour and double coin
        repeat (7) drive_coins(0, 1);
        check("t4_credit14", credit, 14);
        drive_coins(0, 1);
        check("t4_rej", coin_reject, 1);
        check("t4_rej_credit", credit, 14);
        drive_coins(1, 0);
        check("t4_acc", coin_reject, 0);
        check("t4_credit15", credit, 15);
        drive_coins(1, 0);
        check("t4_rej_at_max", coin_reject, 1);
        check("t4_credit_max", credit, 15);
        flush("t4_flush15");
        drive_coins(1, 1);
        check("t4_both", credit, 3);
        check("t4_both_rej", coin_reject, 0);
        flush("t4_flush3");

        // 5: timeout refund
        drive_coins(0, 1);
        check("t5_credit2", credit, 2);
        repeat (TIMEOUT - 1) step();
        check("t5_pre_busy", busy, 1);
        check("t5_pre_change", change, 0);
        step();
        check("t5_change_a", change, 1);
        check("t5_credit_a", credit, 2);
        step();
        check("t5_change_b", change, 1);
        check("t5_credit_b", credit, 1);
        step();
        check("t5_change_end", change, 0);
        check("t5_busy_end", busy, 0);

        // 6: async reset during dispense; later disp_done ignored
        repeat (2) drive_coins(0, 1);
        pulse_sel(2'b10);
        check("t6_req", disp_req, 1);
        check("t6_sel", disp_sel, 2);
        check("t6_credit", credit, 1);
        #2;
        reset = 1'b1;
        #1;
        check("t6_async_outs", {disp_req, disp_sel, change, coin_reject, deny, busy}, 0);
        check("t6_async_credit", credit, 0);
        step();
        reset = 1'b0;
        step();
        pulse_done();
        check("t6_done_ignored", {disp_req, change, busy}, 0);
        check("t6_credit_stay0", credit, 0);

        // 7: exact-price vend goes straight to IDLE; coin on VEND entry rejected
        drive_coins(1, 0);
        coin_1 = 1'b1;
        pulse_sel(2'b00);
        coin_1 = 1'b0;
        check("t7_req", disp_req, 1);
        check("t7_entry_rej", coin_reject, 1);
        check("t7_credit0", credit, 0);
        pulse_done();
        check("t7_idle", {disp_req, change, busy}, 0);

        // report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
